// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cube_pkg
//  Purpose  : Shared types and constants for the time-shared cube engine.
//  Revision : 1.0  initial release
// ============================================================================
package cube_pkg;

   // Engine control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      CU   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int XW_DEF = 7;
   localparam int YW_DEF = 3 * XW_DEF;

   // Cube of the largest XW-bit operand
   function automatic logic [63:0] max_cube(input int xw);
      logic [63:0] m;
      m = (64'd1 << xw) - 64'd1;
      return m * m * m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb
//  Purpose  : Combinational round-robin arbiter. Searches upward from
//             last+1 (mod NREQ) and grants the first valid requester.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb
   import cube_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   input  logic            en,
   output logic [NREQ-1:0] gnt
);

   logic [IDW-1:0] w_idx;
   logic           w_found;

   // Rotating priority search; yields at most one grant bit
   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = IDW'((int'(last) + k) % NREQ);
         if (en && !w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cube_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cube_sched
//  Purpose  : Round-robin arbitrated cube engine. The granted operand is
//             squared and then cubed on one shift-add multiplier (one
//             multiplier bit per cycle) and returned with its requester ID.
//  Revision : 1.0  initial release
// ============================================================================
module cube_sched
   import cube_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int XW   = XW_DEF,
   parameter int YW   = 3 * XW,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*XW-1:0] req_x,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [YW-1:0]      rsp_y,
   input  logic               rsp_ready,
   output logic               busy
);

   localparam int             CW       = (XW > 1) ? $clog2(XW) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(XW - 1);

   state_t              state_q;
   logic [XW-1:0]       x_q;
   logic [IDW-1:0]      id_q;
   logic [IDW-1:0]      last_q;
   logic [2*XW-1:0]     sq_q;
   logic [YW-1:0]       acc_q;
   logic [CW-1:0]       cnt_q;
   logic                rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   logic [YW-1:0]       rsp_y_q;

   logic [NREQ-1:0]     w_gnt;
   logic [IDW-1:0]      w_gnt_id;
   logic [YW-1:0]       w_addend;
   logic [YW-1:0]       acc_d;

   // Grants are only offered while idle
   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req  (req_valid),
      .last (last_q),
      .en   (state_q == IDLE),
      .gnt  (w_gnt)
   );

   // One-hot grant to requester index
   always_comb begin
      w_gnt_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) w_gnt_id = IDW'(i);
      end
   end

   // Shift-add step: multiplicand is x while squaring, sq while cubing
   always_comb begin
      w_addend = '0;
      if (x_q[cnt_q]) begin
         if (state_q == SQ) w_addend = YW'(x_q) << cnt_q;
         else               w_addend = YW'(sq_q) << cnt_q;
      end
      acc_d = acc_q + w_addend;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         id_q        <= '0;
         last_q      <= IDW'(NREQ - 1);
         sq_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|w_gnt) begin
                  x_q     <= req_x[w_gnt_id*XW +: XW];
                  id_q    <= w_gnt_id;
                  last_q  <= w_gnt_id;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= SQ;
               end
            end
            SQ: begin
               if (cnt_q == CNT_LAST) begin
                  sq_q    <= acc_d[2*XW-1:0];
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= CU;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CU: begin
               if (cnt_q == CNT_LAST) begin
                  rsp_y_q     <= acc_d;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  state_q     <= RESP;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = w_gnt;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cube_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cube_sched
//  Purpose  : Self-checking bench for cube_sched (directed vectors plus
//             multi-cycle sequences for arbitration, stall and reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cube_sched;
   import cube_pkg::*;

   localparam int NREQ = 4;
   localparam int XW   = 7;
   localparam int YW   = 21;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*XW-1:0] req_x;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [YW-1:0]      rsp_y;
   logic               rsp_ready;
   logic               busy;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int seen2 = 0;
   bit mon_en = 1'b0;

   cube_sched #(
      .NREQ (NREQ),
      .XW   (XW),
      .YW   (YW),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en && rsp_valid && rsp_id == 2'd2) seen2 <= seen2 + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      int            idx;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic set_x(input int i, input logic [XW-1:0] v);
      req_x[i*XW +: XW] = v;
   endtask

   // Wait for an idle grant, check it, let the acceptance edge pass
   task automatic wait_grant(input int exp, input bit drop, output int gcyc);
      int n;
      n = 0;
      #1;
      while (req_ready == '0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 64'(req_ready), 64'(1) << exp);
      gcyc = cyc;
      @(posedge clk);
      @(negedge clk);
      if (drop) req_valid[exp] = 1'b0;
   endtask

   // Count edges from acceptance to rsp_valid, then check the payload
   task automatic wait_rsp(input int exp_id, input logic [YW-1:0] exp_y);
      int n;
      n = 0;
      while (!rsp_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'd14);
      chk("rsp_y", 64'(rsp_y), 64'(exp_y));
      chk("rsp_id", 64'(rsp_id), 64'(exp_id));
      chk("busy_resp", 64'(busy), 64'd1);
   endtask

   initial begin
      int g, prev, stale;
      int ord[5];
      logic [YW-1:0] cy[5];

      vt[0] = '{0, 7'd5,   21'd125};
      vt[1] = '{1, 7'd0,   21'd0};
      vt[2] = '{2, 7'd1,   21'd1};
      vt[3] = '{3, 7'd127, 21'(max_cube(XW))};
      vt[4] = '{0, 7'd127, 21'd2048383};
      vt[5] = '{2, 7'd10,  21'd1000};
      vt[6] = '{1, 7'd100, 21'd1000000};

      req_valid = '0;
      req_x     = '0;
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_y", 64'(rsp_y), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-requester vectors
      for (int v = 0; v < 7; v++) begin
         set_x(vt[v].idx, vt[v].x);
         req_valid[vt[v].idx] = 1'b1;
         wait_grant(vt[v].idx, 1'b1, g);
         wait_rsp(vt[v].idx, vt[v].y);
      end

      // Continuous demand from all requesters after a fresh reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_x(0, 7'd2); set_x(1, 7'd3); set_x(2, 7'd4); set_x(3, 7'd6);
      req_valid = 4'b1111;
      ord = '{0, 1, 2, 3, 0};
      cy  = '{21'd8, 21'd27, 21'd64, 21'd216, 21'd8};
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(ord[k], 1'b0, g);
         if (k > 0) chk("period", 64'(g - prev), 64'd16);
         prev = g;
         wait_rsp(ord[k], cy[k]);
      end
      req_valid = '0;
      @(negedge clk);

      // Backpressure in RESP with another requester waiting
      set_x(1, 7'd9);
      req_valid[1] = 1'b1;
      rsp_ready = 1'b0;
      wait_grant(1, 1'b1, g);
      set_x(2, 7'd2);
      req_valid[2] = 1'b1;
      wait_rsp(1, 21'd729);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_valid", 64'(rsp_valid), 64'd1);
         chk("stall_y", 64'(rsp_y), 64'd729);
         chk("stall_id", 64'(rsp_id), 64'd1);
         chk("stall_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_stall_valid", 64'(rsp_valid), 64'd0);
      chk("post_stall_busy", 64'(busy), 64'd0);
      chk("post_stall_grant", 64'(req_ready), 64'd4);
      wait_grant(2, 1'b1, g);
      wait_rsp(2, 21'd8);
      @(negedge clk);

      // Asynchronous reset in the middle of CU
      set_x(1, 7'd7);
      req_valid[1] = 1'b1;
      wait_grant(1, 1'b1, g);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_valid", 64'(rsp_valid), 64'd0);
      chk("arst_y", 64'(rsp_y), 64'd0);
      chk("arst_id", 64'(rsp_id), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      chk("stale_rsp", 64'(stale), 64'd0);
      set_x(0, 7'd3);
      set_x(3, 7'd5);
      req_valid = 4'b1001;
      wait_grant(0, 1'b1, g);
      req_valid = '0;
      wait_rsp(0, 21'd27);
      @(negedge clk);

      // Requester 2 withdraws before its turn
      mon_en = 1'b1;
      set_x(1, 7'd11); set_x(2, 7'd12); set_x(3, 7'd13);
      req_valid = 4'b1110;
      wait_grant(1, 1'b0, g);
      req_valid[2] = 1'b0;
      wait_rsp(1, 21'd1331);
      wait_grant(3, 1'b0, g);
      wait_rsp(3, 21'd2197);
      req_valid = '0;
      repeat (40) @(negedge clk);
      chk("no_id2_rsp", 64'(seen2), 64'd0);
      chk("final_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cube_sched.md
# cube_sched

Time-shared cube engine with request arbitration. Up to NREQ requesters each submit an unsigned XW-bit operand. A round-robin arbiter grants one requester at a time. The winning operand is cubed on a single sequential shift-add multiplier, and the result is returned on a shared, ID-tagged response channel. This replaces per-requester combinational cube units in the Snell-law datapath with one engine, which saves area.

## Interface
- NREQ, 4: number of requesters, 2..8
- XW, 7: operand width
- YW, 3*XW: result width (21 at default)
- IDW, $clog2(NREQ): requester ID width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_x  in  NREQ*XW  operands; requester i at bits [i*XW +: XW]
- req_ready  out  NREQ  one-hot grant; at most one bit high
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  index of the requester that owns rsp_y
- rsp_y  out  YW  x*x*x, unsigned
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE

## Operation
- Reset and clock: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, busy = 0
  - round-robin pointer last = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, SQ, CU, RESP.
- IDLE:
  - req_ready is combinational. It has exactly one bit set: the first i with req_valid[i]=1, searching from last+1 upward modulo NREQ.
  - If no requester is valid, req_ready = 0.
  - A transfer happens when req_valid[i] & req_ready[i] at a clock edge. On that edge:
    - latch x = req_x[i] and id = i
    - set last = i
    - clear the accumulator and set bit count = 0
    - go to SQ.
- SQ computes x*x by shift-add, one multiplier bit per cycle, LSB first:
  - if x[cnt], acc += x << cnt; then cnt++.
  - After XW cycles, latch sq = acc (2*XW bits), clear acc and cnt, go to CU.
- CU computes sq*x in the same way:
  - if x[cnt], acc += sq << cnt.
  - After XW cycles, register rsp_y = acc and rsp_id = id, go to RESP.
- Widths: the accumulator is YW bits. No overflow is possible, because the maximum (2^XW-1)^3 is less than 2^YW. All arithmetic is unsigned.
- RESP:
  - rsp_valid = 1. rsp_y and rsp_id hold stable until the handshake.
  - On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. rsp_y keeps its last value.
- req_ready is 0 in every state except IDLE. A request is never accepted in the cycle its response is consumed.
- Requesters hold req_valid and req_x stable until granted. Dropping req_valid before the grant is legal; that requester is simply not granted.
- Reset asserted mid-operation aborts immediately: the in-flight result is discarded and no response is issued.

## Timing
- The acceptance edge is E0. SQ occupies edges E1..E_XW; CU occupies E_XW+1..E_2XW.
- rsp_valid rises after edge E_2XW, i.e. 2*XW cycles after acceptance (14 at default).
- If rsp_ready is held high, the result is consumed on the first RESP edge, and IDLE is re-entered 2*XW+1 cycles after E0.
- The next grant is possible at the following edge, so peak throughput is one result per 2*XW+2 cycles (16 at default).
- Under continuous demand from all requesters, grants rotate 0,1,2,3,0,… Worst-case wait for any requester is NREQ-1 full service slots.
- Backpressure on rsp_ready stalls the FSM in RESP indefinitely. No request is granted during the stall.

## Structure
- Shared package cube_pkg:
  - state enum {IDLE, SQ, CU, RESP}
  - default XW and YW constants
  - function for the max-operand cube value, used by the testbench.
- Sub-module rr_arb:
  - parameter NREQ
  - inputs req, last, en
  - output one-hot gnt
  - purely combinational; the last pointer stays in cube_sched.
- The shift-add datapath and the FSM live in cube_sched.

## Test plan
- Reset, then single request on req 0 with x=5 → req_ready[0] high in IDLE; rsp_valid exactly 14 cycles after acceptance with rsp_y=125, rsp_id=0.
- Boundary operands x=0, x=1, x=127 → rsp_y = 0, 1, and 2048383 respectively; no overflow.
- All four requesters valid continuously, with x = 2,3,4,6 on requesters 0..3, rsp_ready=1 → grant order 0,1,2,3,0; results 8, 27, 64, 216; one response every 16 cycles.
- rsp_ready held low for 10 cycles in RESP → rsp_valid, rsp_y, rsp_id stable throughout; req_ready stays 0; IDLE entered on the edge after rsp_ready rises.
- rst_n pulsed low mid-CU, then a new request with x=3 → no stale response after reset; outputs return to reset values asynchronously; next result is 27 with pointer priority restarting at requester 0.
- Requester 2 drops req_valid before its turn while requesters 1 and 3 stay valid → grants go to 1 then 3; requester 2 is never granted and no response carries rsp_id=2.
